// File: rtl/top_ram_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package top_ram_arb_pkg;

    localparam int DEF_ADDR_W   = 15;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_HOLD = 8;

    // One byte-enable lane per 8 data bits.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Master identity carried alongside each accepted command.
    typedef enum logic {
        M_CPU = 1'b0,
        M_DMA = 1'b1
    } mid_t;

endpackage

// File: rtl/top_ram_arb_rr.sv
// Round-robin grant with bounded hold between the CPU and DMA masters.
// Latency: grant is combinational from the requests; the ownership state updates on the accepting edge.
// Backpressure: the loser of a conflict is held off; a non-requesting master is never held off.
module top_ram_arb_rr
    import top_ram_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    localparam int            HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    mid_t          last_grant_q, last_grant_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    // Low after reset: no streak is running yet, so a tie goes to the
    // master that was not granted last (m0), not to the nominal owner.
    logic          streak_q, streak_d;
    logic          keep_owner;
    logic          acc;
    mid_t          win;

    // Pick the winner: the owner keeps the port until its hold budget runs out.
    always_comb begin
        keep_owner = streak_q && (hold_cnt_q < HOLD_MAX);
        win        = last_grant_q;
        if (req0_i && req1_i) begin
            win = keep_owner ? last_grant_q : mid_t'(~last_grant_q);
        end else if (req0_i) begin
            win = M_CPU;
        end else if (req1_i) begin
            win = M_DMA;
        end
        acc    = req0_i | req1_i;
        gnt0_o = acc && (win == M_CPU);
        gnt1_o = acc && (win == M_DMA);
    end

    // Ownership bookkeeping: extend the streak or hand ownership over.
    always_comb begin
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        streak_d     = streak_q;
        if (acc) begin
            streak_d = 1'b1;
            if (streak_q && (win == last_grant_q)) begin
                if (hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end else begin
                last_grant_d = win;
                hold_cnt_d   = '0;
            end
        end
    end

    // Ownership state registers; m1 is the nominal last owner out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= M_DMA;
            hold_cnt_q   <= '0;
            streak_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            streak_q     <= streak_d;
        end
    end

endmodule

// File: rtl/top_ram_arbiter.sv
// Shares one single-port RAM between the Nios data master (m0) and the line-buffer DMA (m1).
// Latency: accepted op reaches the RAM one cycle later; read data valid exactly 2 cycles after accept.
// Backpressure: per-master waitrequest from the round-robin grant; one op per cycle, no bubbles.
// Optional: define RAM_ARB_WRITE_PROTECT_EN to drop m1 writes below PROTECT_TOP and pulse prot_err.
module top_ram_arbiter
    import top_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
`ifdef RAM_ARB_WRITE_PROTECT_EN
    ,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(32'h1000)
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic [be_width(DATA_W)-1:0] m0_byteenable,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic [be_width(DATA_W)-1:0] m1_byteenable,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    output logic [ADDR_W-1:0]           ram_address,
    output logic [be_width(DATA_W)-1:0] ram_byteenable,
    output logic [DATA_W-1:0]           ram_writedata,
    output logic                        ram_chipselect,
    output logic                        ram_write,
    output logic                        ram_clken,
    input  logic [DATA_W-1:0]           ram_readdata,
    output logic                        prot_err
);

    localparam int BE_W = be_width(DATA_W);

    logic              req0, req1;
    logic              gnt0, gnt1;
    logic              acc;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;
    mid_t              sel_id;
    logic              drop;

    // Command stage towards the RAM.
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    // Read-return tracking: stage 1 lines up with the RAM access, stage 2 with q.
    logic              rv1_q, rv1_d;
    mid_t              rid1_q, rid1_d;
    logic              rv2_q;
    mid_t              rid2_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    top_ram_arb_rr #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req0_i  (req0),
        .req1_i  (req1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1)
    );

    // Only a requester that lost the grant is stalled.
    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    // Mux the granted master's command; a write takes precedence over a read.
    always_comb begin
        acc      = gnt0 | gnt1;
        sel_id   = gnt1 ? M_DMA : M_CPU;
        sel_wr   = gnt1 ? m1_write      : m0_write;
        sel_addr = gnt1 ? m1_address    : m0_address;
        sel_be   = gnt1 ? m1_byteenable : m0_byteenable;
        sel_wd   = gnt1 ? m1_writedata  : m0_writedata;
    end

`ifdef RAM_ARB_WRITE_PROTECT_EN
    logic prot_err_q;

    // DMA writes into the protected low region are accepted but never reach the RAM.
    assign drop = gnt1 & m1_write & (m1_address < PROTECT_TOP);

    // One-cycle error pulse following a dropped write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= drop;
        end
    end

    assign prot_err = prot_err_q;
`else
    assign drop     = 1'b0;
    assign prot_err = 1'b0;
`endif

    // Next command-stage and read-tracking contents for the op accepted this cycle.
    always_comb begin
        cs_d   = acc & ~drop;
        wr_d   = acc & sel_wr & ~drop;
        addr_d = acc ? sel_addr : addr_q;
        be_d   = (acc & sel_wr) ? sel_be : {BE_W{1'b1}};
        wd_d   = (acc & sel_wr) ? sel_wd : wd_q;
        rv1_d  = acc & ~sel_wr;
        rid1_d = sel_id;
    end

    // Command register and read-return shift register; reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            be_q   <= '0;
            wd_q   <= '0;
            rv1_q  <= 1'b0;
            rid1_q <= M_CPU;
            rv2_q  <= 1'b0;
            rid2_q <= M_CPU;
        end else begin
            cs_q   <= cs_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            be_q   <= be_d;
            wd_q   <= wd_d;
            rv1_q  <= rv1_d;
            rid1_q <= rid1_d;
            rv2_q  <= rv1_q;
            rid2_q <= rid1_q;
        end
    end

    assign ram_address    = addr_q;
    assign ram_byteenable = be_q;
    assign ram_writedata  = wd_q;
    assign ram_chipselect = cs_q;
    assign ram_write      = wr_q;
    assign ram_clken      = 1'b1;

    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rv2_q & (rid2_q == M_CPU);
    assign m1_readdatavalid = rv2_q & (rid2_q == M_DMA);

endmodule
